// File: rtl/f2i_seq_pkg.sv
// Shared float/integer field definitions and the f2i_seq state type.
// The macro block is common with the ALU; the package carries widths and the FSM enum.
`ifndef F2I_DEFS_SVH
`define F2I_DEFS_SVH
`define WORD      15:0
`define FSign     15
`define FExp      14:7
`define FMant     6:0
`define INTMAX    16'h7fff
`define INTMIN    16'h8000
`define F2I_IDLE  2'd0
`define F2I_SHIFT 2'd1
`define F2I_DONE  2'd2
`endif

package f2i_seq_pkg;
    localparam int unsigned WordW  = 16;
    localparam int unsigned CountW = 3;

    typedef enum logic [1:0] {
        IDLE  = `F2I_IDLE,
        SHIFT = `F2I_SHIFT,
        DONE  = `F2I_DONE
    } f2iState_t;
endpackage

// File: rtl/f2i_seq_if.sv
// Operand/result handshake bundle between the f2i unit and its producer/consumer.
interface f2i_seq_if;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] in_data;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] out_data;
    logic        out_sat;

    modport master (output in_valid, in_data, out_ready,
                    input  in_ready, out_valid, out_data, out_sat);
    modport slave  (input  in_valid, in_data, out_ready,
                    output in_ready, out_valid, out_data, out_sat);
endinterface

// File: rtl/f2i_seq.sv
// Iterative float16 (1/8/7, biased exponent) to int16 converter: truncates toward zero,
// saturates at the int16 limits, shifts the significand one bit per cycle.
module f2i_seq
    import f2i_seq_pkg::*;
#(
    parameter int unsigned BIAS = 127
) (
    input  logic      clk,
    input  logic      reset,
    f2i_seq_if.slave  bus
);

    localparam logic [7:0] ExpMin = 8'(BIAS);
    localparam logic [7:0] ExpK0  = 8'(BIAS + 7);
    localparam logic [7:0] ExpTop = 8'(BIAS + 15);

    f2iState_t         state, stateNxt;
    logic [`WORD]      acc, accNxt;
    logic [CountW-1:0] count, countNxt;
    logic              shiftLeft, shiftLeftNxt;
    logic              neg, negNxt;
    logic [`WORD]      outData, outDataNxt;
    logic              outSat, outSatNxt;
    logic              outValid, outValidNxt;
    logic              inReady, inReadyNxt;

    logic              fSign;
    logic [7:0]        fExp;
    logic [6:0]        fMant;
    logic              isZero, isSat, isMin, isSpecial, kLeft, accept;
    logic [CountW-1:0] kMag;

    assign fSign     = bus.in_data[`FSign];
    assign fExp      = bus.in_data[`FExp];
    assign fMant     = bus.in_data[`FMant];
    assign accept    = bus.in_valid && inReady;
    assign isSpecial = isZero || isSat || isMin;

    // Operand classification: special classes bypass the shifter entirely.
    always_comb begin
        isZero = 1'b0;
        isSat  = 1'b0;
        isMin  = 1'b0;
        kLeft  = 1'b0;
        kMag   = '0;
        if (fExp == 8'd0 || fExp < ExpMin) begin
            isZero = 1'b1;
        end else if (fExp == 8'hff) begin
            isSat = 1'b1;
        end else if (fExp == ExpTop && fMant == 7'd0 && fSign) begin
            isMin = 1'b1;
        end else if (fExp >= ExpTop) begin
            isSat = 1'b1;
        end else if (fExp >= ExpK0) begin
            kLeft = 1'b1;
            kMag  = CountW'(fExp - ExpK0);
        end else begin
            kMag  = CountW'(ExpK0 - fExp);
        end
    end

    // State and datapath registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            acc       <= '0;
            count     <= '0;
            shiftLeft <= 1'b0;
            neg       <= 1'b0;
            outData   <= '0;
            outSat    <= 1'b0;
            outValid  <= 1'b0;
            inReady   <= 1'b1;
        end else begin
            state     <= stateNxt;
            acc       <= accNxt;
            count     <= countNxt;
            shiftLeft <= shiftLeftNxt;
            neg       <= negNxt;
            outData   <= outDataNxt;
            outSat    <= outSatNxt;
            outValid  <= outValidNxt;
            inReady   <= inReadyNxt;
        end
    end

    always_comb begin
        stateNxt = state;
        case (state)
            IDLE:    if (accept) stateNxt = isSpecial ? DONE : SHIFT;
            SHIFT:   if (count == '0) stateNxt = DONE;
            DONE:    if (bus.out_ready) stateNxt = IDLE;
            default: stateNxt = IDLE;
        endcase
    end

    always_comb begin
        accNxt       = acc;
        countNxt     = count;
        shiftLeftNxt = shiftLeft;
        negNxt       = neg;
        outDataNxt   = outData;
        outSatNxt    = outSat;
        case (state)
            IDLE: begin
                if (accept) begin
                    negNxt = fSign;
                    if (isZero) begin
                        outDataNxt = '0;
                        outSatNxt  = 1'b0;
                    end else if (isMin) begin
                        outDataNxt = `INTMIN;
                        outSatNxt  = 1'b0;
                    end else if (isSat) begin
                        outDataNxt = fSign ? `INTMIN : `INTMAX;
                        outSatNxt  = 1'b1;
                    end else begin
                        accNxt       = {8'd0, 1'b1, fMant};
                        countNxt     = kMag;
                        shiftLeftNxt = kLeft;
                    end
                end
            end
            SHIFT: begin
                if (count != '0) begin
                    accNxt   = shiftLeft ? {acc[14:0], 1'b0} : {1'b0, acc[15:1]};
                    countNxt = count - CountW'(1);
                end else begin
                    // Magnitude is at most 0x7F80, so negation cannot wrap.
                    outDataNxt = neg ? (~acc + WordW'(1)) : acc;
                    outSatNxt  = 1'b0;
                end
            end
            default: ;
        endcase
        outValidNxt = (stateNxt == DONE);
        inReadyNxt  = (stateNxt == IDLE);
    end

    assign bus.in_ready  = inReady;
    assign bus.out_valid = outValid;
    assign bus.out_data  = outData;
    assign bus.out_sat   = outSat;

endmodule

// File: tb/tb_f2i_seq.sv
// Scoreboard bench for f2i_seq: directed operands, backpressure and mid-operation reset.
module tb_f2i_seq;

    typedef struct {
        logic [15:0] din;
        logic [15:0] data;
        logic        sat;
        int          lat;
    } expRes_t;

    logic clk = 1'b0;
    logic reset = 1'b1;
    int   nChecks = 0;
    int   nFail = 0;
    expRes_t sbQ[$];

    f2i_seq_if bus ();

    f2i_seq #(.BIAS(127)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic checkVal(input string tag, input logic [31:0] got, input logic [31:0] exp);
        nChecks++;
        if (got !== exp) begin
            nFail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Drive one operand and push its expectation.
    task automatic sendOp(input logic [15:0] din, input logic [15:0] eData,
                          input logic eSat, input int eLat);
        expRes_t e;
        e.din = din; e.data = eData; e.sat = eSat; e.lat = eLat;
        @(negedge clk);
        checkVal($sformatf("in_ready before %h", din), 32'(bus.in_ready), 32'd1);
        bus.in_valid = 1'b1;
        bus.in_data  = din;
        sbQ.push_back(e);
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        bus.in_data  = 16'hdead;
    endtask

    // Wait for the result, compare against the popped expectation; leaves DUT in DONE.
    task automatic waitResult();
        expRes_t e;
        int n = 0;
        bit seen = 0;
        e = sbQ.pop_front();
        for (int i = 1; i <= 30 && !seen; i++) begin
            @(negedge clk);
            if (bus.out_valid) begin
                seen = 1;
                n = i;
            end
        end
        if (!seen) begin
            checkVal($sformatf("timeout %h", e.din), 32'd0, 32'd1);
        end else begin
            checkVal($sformatf("data %h", e.din), 32'(bus.out_data), 32'(e.data));
            checkVal($sformatf("sat %h", e.din), 32'(bus.out_sat), 32'(e.sat));
            checkVal($sformatf("latency %h", e.din), 32'(n), 32'(e.lat));
        end
    endtask

    task automatic releaseResult();
        bus.out_ready = 1'b1;
        @(posedge clk);
        #1;
        bus.out_ready = 1'b0;
        @(negedge clk);
        checkVal("out_valid after take", 32'(bus.out_valid), 32'd0);
        checkVal("in_ready after take", 32'(bus.in_ready), 32'd1);
    endtask

    task automatic runOp(input logic [15:0] din, input logic [15:0] eData,
                         input logic eSat, input int eLat);
        sendOp(din, eData, eSat, eLat);
        waitResult();
        releaseResult();
    endtask

    initial begin
        bus.in_valid  = 1'b0;
        bus.in_data   = 16'h0000;
        bus.out_ready = 1'b0;
        repeat (2) @(negedge clk);
        checkVal("reset in_ready", 32'(bus.in_ready), 32'd1);
        checkVal("reset out_valid", 32'(bus.out_valid), 32'd0);
        checkVal("reset out_data", 32'(bus.out_data), 32'd0);
        checkVal("reset out_sat", 32'(bus.out_sat), 32'd0);
        reset = 1'b0;

        // Normal path: latency |k|+2.
        runOp(16'h3fc0, 16'h0001, 1'b0, 9);
        runOp(16'h4300, 16'h0080, 1'b0, 2);
        runOp(16'h46ff, 16'h7f80, 1'b0, 9);
        runOp(16'hc2f6, 16'hff85, 1'b0, 3);
        runOp(16'h3f80, 16'h0001, 1'b0, 9);
        runOp(16'hc6ff, 16'h8080, 1'b0, 9);
        // Special classes: one cycle.
        runOp(16'h3f00, 16'h0000, 1'b0, 1);
        runOp(16'h0000, 16'h0000, 1'b0, 1);
        runOp(16'h4700, 16'h7fff, 1'b1, 1);
        runOp(16'hc700, 16'h8000, 1'b0, 1);
        runOp(16'hc780, 16'h8000, 1'b1, 1);
        runOp(16'h7f80, 16'h7fff, 1'b1, 1);
        runOp(16'hffc0, 16'h8000, 1'b1, 1);
        runOp(16'h0040, 16'h0000, 1'b0, 1);

        // Backpressure: result held, new operand ignored.
        sendOp(16'hc2f6, 16'hff85, 1'b0, 3);
        waitResult();
        bus.in_valid = 1'b1;
        bus.in_data  = 16'h4300;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            checkVal($sformatf("bp out_valid %0d", i), 32'(bus.out_valid), 32'd1);
            checkVal($sformatf("bp out_data %0d", i), 32'(bus.out_data), 32'hff85);
            checkVal($sformatf("bp in_ready %0d", i), 32'(bus.in_ready), 32'd0);
        end
        bus.in_valid = 1'b0;
        releaseResult();
        repeat (3) begin
            @(negedge clk);
            checkVal("bp no ghost op", 32'(bus.out_valid), 32'd0);
        end

        // Reset mid-SHIFT discards the operation immediately.
        sendOp(16'h3fc0, 16'h0001, 1'b0, 9);
        void'(sbQ.pop_front());
        repeat (3) @(negedge clk);
        reset = 1'b1;
        #1;
        checkVal("rst out_valid", 32'(bus.out_valid), 32'd0);
        checkVal("rst in_ready", 32'(bus.in_ready), 32'd1);
        @(negedge clk);
        reset = 1'b0;
        runOp(16'h4300, 16'h0080, 1'b0, 2);

        checkVal("scoreboard empty", 32'(sbQ.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFail);
        $finish;
    end

endmodule
